// File: rtl/bypass_fwd_if.sv
// Bus bundle for the write/read forwarding unit: two PE write halves,
// four operand read ports and the corrected operand outputs.
interface bypass_fwd_if #(
  parameter int unsigned P  = 128,
  parameter int unsigned Q  = 6,
  parameter int unsigned AW = 7
);
  localparam int unsigned W = P * Q;

  logic                 flush;
  logic [1:0]           wr_vld;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][P-1:0]    wr_mask;
  logic [1:0][W-1:0]    wr_data;
  logic [3:0]           rd_vld;
  logic [3:0][AW-1:0]   rd_addr;
  logic [3:0][W-1:0]    rd_data;
  logic [3:0]           out_vld;
  logic [3:0][W-1:0]    out_data;
  logic [3:0]           fwd_hit;
  logic [15:0]          hit_cnt;
  logic                 wr_conflict;

  modport master (
    output flush, wr_vld, wr_addr, wr_mask, wr_data, rd_vld, rd_addr, rd_data,
    input  out_vld, out_data, fwd_hit, hit_cnt, wr_conflict
  );

  modport slave (
    input  flush, wr_vld, wr_addr, wr_mask, wr_data, rd_vld, rd_addr, rd_data,
    output out_vld, out_data, fwd_hit, hit_cnt, wr_conflict
  );
endinterface

// File: rtl/bypass_fwd_unit.sv
// Write-to-read bypass: patches storage read data with PE writes that are
// not yet visible in storage, lane by lane, youngest write winning.
module bypass_fwd_unit #(
  parameter int unsigned P  = 128,
  parameter int unsigned Q  = 6,
  parameter int unsigned AW = 7,
  parameter int unsigned D  = 3
) (
  input  logic          clk,
  input  logic          rst,
  bypass_fwd_if.slave   bus
);
  localparam int unsigned W  = P * Q;
  localparam int unsigned RD = (D > 1) ? D - 1 : 1;

  // registered history, r_*[0] is age 1
  logic [1:0]         r_vld  [RD];
  logic [1:0][AW-1:0] r_addr [RD];
  logic [1:0][P-1:0]  r_mask [RD];
  logic [1:0][W-1:0]  r_data [RD];

  // full history view, index 0 is the live write
  logic [1:0]         h_vld  [D];
  logic [1:0][AW-1:0] h_addr [D];
  logic [1:0][P-1:0]  h_mask [D];
  logic [1:0][W-1:0]  h_data [D];

  logic [3:0][W-1:0]  out_d;
  logic [3:0]         hit_d;
  logic               conflict_c;

  if (D > 1) begin : g_hist
    always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
        r_vld <= '{default: '0};
      end else begin
        r_vld[0] <= bus.wr_vld;
        for (int a = 1; a < int'(RD); a++) r_vld[a] <= r_vld[a-1];
      end
      r_addr[0] <= bus.wr_addr;
      r_mask[0] <= bus.wr_mask;
      r_data[0] <= bus.wr_data;
      for (int a = 1; a < int'(RD); a++) begin
        r_addr[a] <= r_addr[a-1];
        r_mask[a] <= r_mask[a-1];
        r_data[a] <= r_data[a-1];
      end
    end
  end else begin : g_no_hist
    always_comb begin
      r_vld  = '{default: '0};
      r_addr = '{default: '0};
      r_mask = '{default: '0};
      r_data = '{default: '0};
    end
  end

  always_comb begin
    h_vld[0]  = bus.wr_vld;
    h_addr[0] = bus.wr_addr;
    h_mask[0] = bus.wr_mask;
    h_data[0] = bus.wr_data;
    for (int a = 1; a < int'(D); a++) begin
      h_vld[a]  = r_vld[a-1];
      h_addr[a] = r_addr[a-1];
      h_mask[a] = r_mask[a-1];
      h_data[a] = r_data[a-1];
    end
  end

  // oldest-to-youngest scan, half 1 after half 0, so later matches override
  always_comb begin
    out_d = '0;
    hit_d = '0;
    for (int j = 0; j < 4; j++) begin
      if (bus.rd_vld[j]) begin
        out_d[j] = bus.rd_data[j];
        for (int i = 0; i < int'(P); i++) begin
          for (int a = int'(D) - 1; a >= 0; a--) begin
            for (int h = 0; h < 2; h++) begin
              if (h_vld[a][h] && (h_addr[a][h] == bus.rd_addr[j]) && h_mask[a][h][i]) begin
                out_d[j][i*Q +: Q] = h_data[a][h][i*Q +: Q];
                hit_d[j]           = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign conflict_c = (&bus.wr_vld) && (bus.wr_addr[0] == bus.wr_addr[1]) &&
                      (|(bus.wr_mask[0] & bus.wr_mask[1]));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_vld     <= '0;
      bus.out_data    <= '0;
      bus.fwd_hit     <= '0;
      bus.hit_cnt     <= '0;
      bus.wr_conflict <= 1'b0;
    end else begin
      bus.out_vld  <= bus.rd_vld;
      bus.out_data <= out_d;
      bus.fwd_hit  <= hit_d;
      if ((|hit_d) && (bus.hit_cnt != 16'hFFFF)) bus.hit_cnt <= bus.hit_cnt + 16'd1;
      if (conflict_c) bus.wr_conflict <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bypass_fwd_unit.sv
// Directed bench for bypass_fwd_unit: per-cycle expectations are queued as
// stimulus is driven and checked one cycle later against the outputs.
module tb_bypass_fwd_unit;
  localparam int unsigned P  = 4;
  localparam int unsigned Q  = 6;
  localparam int unsigned AW = 7;
  localparam int unsigned D  = 3;
  localparam int unsigned W  = P * Q;

  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    logic         hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bypass_fwd_if #(.P(P), .Q(Q), .AW(AW)) bus ();

  bypass_fwd_unit #(.P(P), .Q(Q), .AW(AW), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  exp_t        stage [4];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt;
  logic        exp_conf;

  function automatic logic [W-1:0] lanes(input logic [5:0] l0, input logic [5:0] l1,
                                         input logic [5:0] l2, input logic [5:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush   = 1'b0;
    bus.wr_vld  = '0;
    bus.wr_addr = '0;
    bus.wr_mask = '0;
    bus.wr_data = '0;
    bus.rd_vld  = '0;
    bus.rd_addr = '0;
    bus.rd_data = '0;
    for (int j = 0; j < 4; j++) stage[j] = '{1'b0, '0, 1'b0};
  endtask

  task automatic wr(input int h, input logic [AW-1:0] a, input logic [P-1:0] m,
                    input logic [W-1:0] d);
    bus.wr_vld[h]  = 1'b1;
    bus.wr_addr[h] = a;
    bus.wr_mask[h] = m;
    bus.wr_data[h] = d;
  endtask

  task automatic rd(input int j, input logic [AW-1:0] a, input logic [W-1:0] raw,
                    input logic [W-1:0] exp, input logic hit);
    bus.rd_vld[j]  = 1'b1;
    bus.rd_addr[j] = a;
    bus.rd_data[j] = raw;
    stage[j]       = '{1'b1, exp, hit};
  endtask

  // queue this cycle's expectations, clock once, then score the outputs
  task automatic tick();
    logic any_hit;
    exp_t e;
    any_hit = 1'b0;
    if (rst) for (int j = 0; j < 4; j++) stage[j] = '{1'b0, '0, 1'b0};
    for (int j = 0; j < 4; j++) begin
      sb.push_back(stage[j]);
      any_hit |= stage[j].hit;
    end
    if (rst) begin
      exp_cnt  = '0;
      exp_conf = 1'b0;
    end else begin
      if (any_hit && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (bus.wr_vld == 2'b11 && bus.wr_addr[0] == bus.wr_addr[1] &&
          (|(bus.wr_mask[0] & bus.wr_mask[1]))) exp_conf = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      e = sb.pop_front();
      chk($sformatf("p%0d_vld", j),  W'(bus.out_vld[j]), W'(e.vld));
      chk($sformatf("p%0d_data", j), bus.out_data[j],    e.data);
      chk($sformatf("p%0d_hit", j),  W'(bus.fwd_hit[j]), W'(e.hit));
    end
    chk("hit_cnt",     W'(bus.hit_cnt),     W'(exp_cnt));
    chk("wr_conflict", W'(bus.wr_conflict), W'(exp_conf));
  endtask

  initial begin
    logic [W-1:0] l1234, l3f, l9;
    l1234    = lanes(6'd1, 6'd2, 6'd3, 6'd4);
    l3f      = lanes(6'h3F, 6'h3F, 6'h3F, 6'h3F);
    l9       = lanes(6'd9, 6'd9, 6'd9, 6'd9);
    exp_cnt  = '0;
    exp_conf = 1'b0;

    // reset with activity that must be discarded
    rst = 1'b1;
    idle();
    wr(0, 7'd5, 4'hF, l1234);
    wr(1, 7'd5, 4'hF, l1234);
    rd(0, 7'd5, l9, l1234, 1'b1);
    tick();
    tick();
    rst = 1'b0;

    // first cycle out of reset: nothing in history
    idle();
    rd(0, 7'd5, l3f, l3f, 1'b0);
    tick();

    // full-word write seen by all four ports at age 2
    idle(); wr(0, 7'd5, 4'hF, l1234); tick();
    idle(); tick();
    idle();
    for (int j = 0; j < 4; j++) rd(j, 7'd5, l3f, l1234, 1'b1);
    tick();
    // window expired; inactive port with matching address stays quiet
    idle();
    rd(0, 7'd5, l9, l9, 1'b0);
    bus.rd_addr[1] = 7'd5;
    bus.rd_data[1] = l9;
    tick();

    // partial mask, same-cycle (age 0) and next-cycle hits, address miss
    idle();
    wr(0, 7'd5, 4'b0011, l1234);
    rd(2, 7'd5, l9, lanes(6'd1, 6'd2, 6'd9, 6'd9), 1'b1);
    tick();
    idle();
    rd(3, 7'd5, l9, lanes(6'd1, 6'd2, 6'd9, 6'd9), 1'b1);
    rd(0, 7'd6, l9, l9, 1'b0);
    tick();

    // younger half 0 beats older half 1
    idle(); wr(1, 7'd3, 4'hF, lanes(6'd7, 6'd7, 6'd7, 6'd7)); tick();
    idle(); wr(0, 7'd3, 4'hF, lanes(6'd8, 6'd8, 6'd8, 6'd8)); tick();
    idle(); rd(1, 7'd3, '0, lanes(6'd8, 6'd8, 6'd8, 6'd8), 1'b1); tick();

    // both halves, same address, disjoint masks: merge, no conflict
    idle();
    wr(0, 7'd2, 4'b1100, lanes(6'd0, 6'd0, 6'd10, 6'd11));
    wr(1, 7'd2, 4'b0011, lanes(6'd12, 6'd13, 6'd0, 6'd0));
    rd(0, 7'd2, l9, lanes(6'd12, 6'd13, 6'd10, 6'd11), 1'b1);
    tick();
    // overlapping masks: half 1 wins lane 0, older merge fills the rest
    idle();
    wr(0, 7'd2, 4'b0001, lanes(6'd20, 6'd0, 6'd0, 6'd0));
    wr(1, 7'd2, 4'b0001, lanes(6'd30, 6'd0, 6'd0, 6'd0));
    rd(1, 7'd2, l9, lanes(6'd30, 6'd13, 6'd10, 6'd11), 1'b1);
    tick();
    idle(); tick();
    chk("conflict_sticky", W'(bus.wr_conflict), W'(1'b1));

    // flush: lookup in the flush cycle still sees history, afterwards not
    idle(); tick(); tick();
    idle(); wr(0, 7'd1, 4'hF, lanes(6'd5, 6'd5, 6'd5, 6'd5)); tick();
    idle();
    bus.flush = 1'b1;
    wr(0, 7'd4, 4'hF, l9);
    rd(0, 7'd1, l3f, lanes(6'd5, 6'd5, 6'd5, 6'd5), 1'b1);
    tick();
    idle();
    rd(0, 7'd1, l3f, l3f, 1'b0);
    rd(1, 7'd4, l3f, l3f, 1'b0);
    tick();

    // saturate the hit counter
    for (int n = 0; n < 70000; n++) begin
      idle();
      wr(0, 7'd0, 4'hF, lanes(6'd1, 6'd1, 6'd1, 6'd1));
      rd(0, 7'd0, '0, lanes(6'd1, 6'd1, 6'd1, 6'd1), 1'b1);
      tick();
    end
    chk("hit_cnt_sat", W'(bus.hit_cnt), W'(16'hFFFF));

    // reset clears everything, including the sticky conflict flag
    idle();
    rst = 1'b1;
    wr(0, 7'd0, 4'hF, l9);
    wr(1, 7'd0, 4'hF, l9);
    rd(0, 7'd0, l3f, l9, 1'b1);
    tick();
    chk("rst_hit_cnt",  W'(bus.hit_cnt),     '0);
    chk("rst_conflict", W'(bus.wr_conflict), '0);
    chk("rst_out_data", bus.out_data[0],     '0);
    rst = 1'b0;
    idle();
    rd(0, 7'd0, lanes(6'd21, 6'd21, 6'd21, 6'd21), lanes(6'd21, 6'd21, 6'd21, 6'd21), 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
